tx_event_player: RTL

- Hardware replay source for the TX signal path: the playback counterpart to the TX time/value logger.
- Buffers (time, value) pairs pushed by a host or loader, then drives the filter input with each value once emulated time reaches its timestamp.
- Sits between the stimulus loader and the TX filter input. Output value is held between events, so the filter sees a piecewise-constant waveform.

---
 rtl/tx_event_player_pkg.sv | 18 +
 rtl/tx_event_player_event_fifo.sv | 58 +++++
 rtl/tx_event_player.sv | 77 +++++++
 3 files changed

// File: rtl/tx_event_player_pkg.sv
// Shared types for the TX event player.
//   TIME_FORMAT      : unsigned fixed-point emulated time, TIME_POINT fractional bits
//   FILTER_IN_FORMAT : signed fixed-point TX filter input, FILTER_IN_POINT fractional bits
//   tx_event_t       : one buffered playback event {timestamp, value}
package tx_event_player_pkg;

  localparam int TIME_POINT = 8;
  typedef logic [31:0] TIME_FORMAT;

  localparam int FILTER_IN_POINT = 12;
  typedef logic signed [15:0] FILTER_IN_FORMAT;

  typedef struct packed {
    TIME_FORMAT      t;
    FILTER_IN_FORMAT v;
  } tx_event_t;

endpackage

// File: rtl/tx_event_player_event_fifo.sv
// Synchronous FIFO of tx_event_t with a combinational head read.
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous flush; discards any same-cycle write or read
//   wr_en    : write din at the tail (caller guarantees not full)
//   rd_en    : drop the head entry (caller guarantees not empty)
//   din      : entry to write
//   dout     : current head entry, valid while level != 0
//   level    : registered entry count, 0..DEPTH
module event_fifo
  import tx_event_player_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      wr_en,
  input  logic      rd_en,
  input  tx_event_t din,
  output tx_event_t dout,
  output logic [AW:0] level
);

  tx_event_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // NOTE: storage is deliberately not reset; only pointers and level define
  // which entries are live, so a reset memory would just cost flops.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/tx_event_player.sv
// TX event player: buffers (time, value) events from a loader and applies each
// value to the TX filter input once emulated time reaches its timestamp.
// The applied value holds between events (piecewise-constant waveform).
//   clk, rst   : clock, synchronous active-high reset
//   emu_time   : current emulated time (monotonic non-decreasing)
//   en         : playback enable; nothing is issued while low
//   flush      : drop all buffered events (output value and late flag kept)
//   in_valid / in_ready / in_time / in_value : event push handshake
//   out_value  : currently applied filter input
//   out_update : one-cycle pulse on every issue
//   level      : number of buffered events
//   late       : sticky, set when an event is issued more than 1 LSB late
module tx_event_player
  import tx_event_player_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  TIME_FORMAT      emu_time,
  input  logic            en,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  TIME_FORMAT      in_time,
  input  FILTER_IN_FORMAT in_value,
  output FILTER_IN_FORMAT out_value,
  output logic            out_update,
  output logic [AW:0]     level,
  output logic            late
);

  tx_event_t  head;
  tx_event_t  din;
  logic       push;
  logic       due;
  TIME_FORMAT lag;

  // Ready looks only at the registered level: a pop while full does not
  // open a slot until the following cycle.
  assign in_ready = (level != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign due      = en && (level != '0) && (emu_time >= head.t);
  assign din      = '{t: in_time, v: in_value};

  // Only meaningful when due, where emu_time >= head.t so no wrap occurs.
  assign lag = emu_time - head.t;

  event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .wr_en (push),
    .rd_en (due),
    .din   (din),
    .dout  (head),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_value  <= '0;
      out_update <= 1'b0;
      late       <= 1'b0;
    end else if (flush) begin
      out_update <= 1'b0;
    end else if (due) begin
      out_value  <= head.v;
      out_update <= 1'b1;
      if (lag > TIME_FORMAT'(1)) late <= 1'b1;
    end else begin
      out_update <= 1'b0;
    end
  end

endmodule
